// File: rtl/cd_hps_sched.sv
// cd_hps_sched: command scheduler for the HPS CD link.
// Queues 96-bit CD commands, issues them one at a time to the HPS bridge by
// toggling hps_cd_in[96], matches each reply toggle on hps_cd_out[96] to the
// outstanding command, and abandons a command whose reply is late.
//
// Ports:
//   clk_sys      system clock, rising edge
//   reset_n      asynchronous active-low reset (release synchronised here)
//   cmd_data/cmd_valid/cmd_ready  command push interface
//   flush        drop queued commands and the outstanding one
//   rsp_data     last reply word, held between replies
//   rsp_valid    one-cycle pulse when rsp_data updates
//   rsp_unsol    with rsp_valid: reply arrived with nothing outstanding
//   rsp_timeout  one-cycle pulse when the outstanding command is abandoned
//   busy         a command is outstanding
//   pending      FIFO occupancy
//   hps_cd_in    to bridge: [95:0] command, [96] request toggle
//   hps_cd_out   from bridge: [95:0] reply, [96] reply toggle
module cd_hps_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] TIMEOUT = 32'd53_000_000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [95:0]            cmd_data,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   flush,
    output logic [95:0]            rsp_data,
    output logic                   rsp_valid,
    output logic                   rsp_unsol,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic [96:0]            hps_cd_in,
    input  logic [96:0]            hps_cd_out
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_PRIME,
        S_IDLE,
        S_WAIT
    } state_t;

    // Reset synchroniser: asserts asynchronously, releases after two edges.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic [95:0]   rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_unsol_q, rsp_unsol_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [96:0]   cin_q, cin_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [95:0]   mem_q [DEPTH];

    logic          new_ack;
    logic          flush_eff;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [95:0]   head;

    assign new_ack    = hps_cd_out[96] != ack_q;
    // flush is ignored during the PRIME cycle so the toggle baseline is taken cleanly.
    assign flush_eff  = flush && (state_q != S_PRIME);
    assign fifo_empty = (wr_q == rd_q);
    assign pending    = wr_q - rd_q;
    assign cmd_ready  = (pending != FULL);
    assign push       = cmd_valid && cmd_ready && !flush_eff;
    assign head       = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= cmd_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        ack_d         = ack_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        rsp_unsol_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        cin_d         = cin_q;
        cnt_d         = cnt_q;
        pop           = 1'b0;

        if (state_q == S_PRIME) begin
            ack_d   = hps_cd_out[96];
            state_d = S_IDLE;
        end else if (flush_eff) begin
            // A coincident reply still moves the baseline but is not reported.
            if (new_ack) begin
                ack_d = hps_cd_out[96];
            end
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (new_ack) begin
                        ack_d       = hps_cd_out[96];
                        rsp_data_d  = hps_cd_out[95:0];
                        rsp_valid_d = 1'b1;
                        rsp_unsol_d = 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        cin_d   = {~cin_q[96], head};
                        cnt_d   = TIMEOUT;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (new_ack) begin
                        ack_d       = hps_cd_out[96];
                        rsp_data_d  = hps_cd_out[95:0];
                        rsp_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (TIMEOUT != 32'd0 && cnt_q == 32'd1) begin
                        rsp_timeout_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_eff) begin
            rd_d = wr_q;
        end else begin
            if (push) begin
                wr_d = wr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_d = rd_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q       <= S_PRIME;
            ack_q         <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_unsol_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cin_q         <= '0;
            cnt_q         <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_unsol_q   <= rsp_unsol_d;
            rsp_timeout_q <= rsp_timeout_d;
            cin_q         <= cin_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
        end
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_unsol   = rsp_unsol_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q == S_WAIT);
    assign hps_cd_in   = cin_q;

endmodule

// File: tb/tb_cd_hps_sched.sv
// Bench for cd_hps_sched: directed stimulus, a queue-based reference model
// compared every cycle, and literal expectations at key points.
module tb_cd_hps_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 100;

    logic        clk_sys    = 1'b0;
    logic        reset_n    = 1'b1;
    logic [95:0] cmd_data   = '0;
    logic        cmd_valid  = 1'b0;
    logic        flush      = 1'b0;
    logic [96:0] hps_cd_out = '0;

    logic        cmd_ready;
    logic [95:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_unsol;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  pending;
    logic [96:0] hps_cd_in;

    int errors = 0;
    int checks = 0;

    cd_hps_sched #(
        .DEPTH   (DEPTH),
        .TIMEOUT (32'(TMO))
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .flush       (flush),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_unsol   (rsp_unsol),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .pending     (pending),
        .hps_cd_in   (hps_cd_in),
        .hps_cd_out  (hps_cd_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: command queue, one outstanding flag with an absolute
    // deadline, and the last reply toggle seen.
    logic [95:0] m_q[$];
    int          rs         = 0;
    int          cyc        = 0;
    int          m_deadline = 0;
    bit          m_prime    = 1'b1;
    bit          m_out      = 1'b0;
    logic        m_ack      = 1'b0;
    logic [96:0] m_cin      = '0;
    logic [95:0] m_rsp      = '0;
    logic        e_valid    = 1'b0;
    logic        e_unsol    = 1'b0;
    logic        e_tmo      = 1'b0;

    initial begin
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                rs      = 0;
                m_prime = 1'b1;
                m_out   = 1'b0;
                m_ack   = 1'b0;
                m_cin   = '0;
                m_rsp   = '0;
                e_valid = 1'b0;
                e_unsol = 1'b0;
                e_tmo   = 1'b0;
            end else begin
                cyc++;
                if (rs < 2) begin
                    rs++;
                end else begin
                    bit   ready;
                    bit   was_prime;
                    logic tog;
                    ready     = (m_q.size() < DEPTH);
                    was_prime = m_prime;
                    tog       = hps_cd_out[96];
                    e_valid   = 1'b0;
                    e_unsol   = 1'b0;
                    e_tmo     = 1'b0;
                    if (m_prime) begin
                        m_ack   = tog;
                        m_prime = 1'b0;
                    end else if (flush) begin
                        m_ack = tog;
                        m_q.delete();
                        m_out = 1'b0;
                    end else if (tog != m_ack) begin
                        m_ack   = tog;
                        m_rsp   = hps_cd_out[95:0];
                        e_valid = 1'b1;
                        e_unsol = !m_out;
                        m_out   = 1'b0;
                    end else if (m_out) begin
                        if (TMO != 0 && cyc == m_deadline) begin
                            e_tmo = 1'b1;
                            m_out = 1'b0;
                        end
                    end else if (m_q.size() > 0) begin
                        m_cin      = {~m_cin[96], m_q.pop_front()};
                        m_out      = 1'b1;
                        m_deadline = cyc + int'(TMO);
                    end
                    if (cmd_valid && ready && !(flush && !was_prime)) begin
                        m_q.push_back(cmd_data);
                    end
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        check("hps_cd_in",   hps_cd_in,            m_cin);
        check("rsp_data",    97'(rsp_data),        97'(m_rsp));
        check("rsp_valid",   97'(rsp_valid),       97'(e_valid));
        check("rsp_unsol",   97'(rsp_unsol),       97'(e_unsol));
        check("rsp_timeout", 97'(rsp_timeout),     97'(e_tmo));
        check("busy",        97'(busy),            97'(m_out));
        check("pending",     97'(pending),         97'(m_q.size()));
        check("cmd_ready",   97'(cmd_ready),       97'(m_q.size() < DEPTH));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic [95:0] d);
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic reply(input logic [95:0] d);
        logic t;
        t = hps_cd_out[96];
        hps_cd_out = {~t, d};
        tick(1);
    endtask

    localparam logic [95:0] CMD1 = 96'h0123_4567_89AB_CDEF_0011_2233;
    localparam logic [95:0] X    = 96'h1111_0000_0000_0000_0000_0001;
    localparam logic [95:0] Y    = 96'h2222_0000_0000_0000_0000_0002;
    localparam logic [95:0] Z    = 96'h3333_0000_0000_0000_0000_0003;
    localparam logic [95:0] P1   = 96'h4444_0000_0000_0000_0000_0001;
    localparam logic [95:0] P5   = 96'h4444_0000_0000_0000_0000_0005;
    localparam logic [95:0] Q1   = 96'hF00D_0000_0000_0000_0000_00F0;

    initial begin
        logic [95:0] c [6];
        logic [96:0] e;
        logic        t;
        int          n;

        for (int i = 0; i < 6; i++) begin
            c[i] = 96'h5000 + 96'(i);
        end

        #1 reset_n = 1'b0;
        tick(3);
        check("rst_hps_cd_in", hps_cd_in, 97'd0);
        check("rst_busy", 97'(busy), 97'd0);
        reset_n = 1'b1;
        tick(4);
        check("init_pending", 97'(pending), 97'd0);
        check("init_ready", 97'(cmd_ready), 97'd1);

        // Single command and solicited reply
        push(CMD1);
        tick(1);
        check("single_issue", hps_cd_in, {1'b1, CMD1});
        check("single_busy", 97'(busy), 97'd1);
        reply(96'hA5);
        check("single_valid", 97'(rsp_valid), 97'd1);
        check("single_data", 97'(rsp_data), 97'hA5);
        check("single_unsol", 97'(rsp_unsol), 97'd0);
        check("single_busy_lo", 97'(busy), 97'd0);
        tick(1);

        // Queue fill: six back-to-back pushes, the sixth arrives while full
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_data = c[i];
            tick(1);
            if (i == 4) begin
                check("fill_pending", 97'(pending), 97'd4);
                check("fill_ready", 97'(cmd_ready), 97'd0);
            end
        end
        cmd_valid = 1'b0;
        check("fill_issue0", hps_cd_in, {1'b0, c[0]});
        check("fill_pending_hold", 97'(pending), 97'd4);
        for (int i = 1; i < 5; i++) begin
            reply(96'hA0 + 96'(i));
            tick(1);
            e = {1'(i % 2), c[i]};
            check("fill_issue", hps_cd_in, e);
        end
        reply(96'hAF);
        tick(1);
        check("fill_drained", 97'(pending), 97'd0);

        // Timeouts, then a late reply racing a queued issue
        push(X);
        tick(1);
        check("tmo_issue_x", hps_cd_in, {1'b1, X});
        push(Y);
        push(Z);
        n = 2;
        while (rsp_timeout !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        check("tmo_x_latency", 97'(n), 97'(TMO));
        tick(1);
        check("tmo_issue_y", hps_cd_in, {1'b0, Y});
        n = 0;
        while (rsp_timeout !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        check("tmo_y_latency", 97'(n), 97'(TMO));
        t = hps_cd_out[96];
        hps_cd_out = {~t, 96'hBEEF};
        tick(1);
        check("late_valid", 97'(rsp_valid), 97'd1);
        check("late_unsol", 97'(rsp_unsol), 97'd1);
        check("late_data", 97'(rsp_data), 97'hBEEF);
        check("late_no_issue", 97'(busy), 97'd0);
        tick(1);
        check("tmo_issue_z", hps_cd_in, {1'b1, Z});
        reply(96'hC0DE);
        check("z_unsol", 97'(rsp_unsol), 97'd0);
        tick(1);

        // Unsolicited reply while idle and empty
        reply(96'h77);
        check("unsol_valid", 97'(rsp_valid), 97'd1);
        check("unsol_flag", 97'(rsp_unsol), 97'd1);
        check("unsol_data", 97'(rsp_data), 97'h77);
        tick(1);
        check("unsol_busy", 97'(busy), 97'd0);

        // Flush with one outstanding and three queued
        push(P1);
        push(P1 + 96'd1);
        push(P1 + 96'd2);
        push(P1 + 96'd3);
        check("flush_pre_pending", 97'(pending), 97'd3);
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 96'hDEAD;
        t = hps_cd_out[96];
        hps_cd_out = {~t, 96'h55};
        tick(1);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("flush_pending", 97'(pending), 97'd0);
        check("flush_valid", 97'(rsp_valid), 97'd0);
        check("flush_busy", 97'(busy), 97'd0);
        check("flush_hold", hps_cd_in, {1'b0, P1});
        tick(3);
        push(P5);
        tick(1);
        check("flush_next", hps_cd_in, {1'b1, P5});

        // Asynchronous reset while waiting, with a stale toggle afterwards
        #2 reset_n = 1'b0;
        #1;
        check("arst_hps_cd_in", hps_cd_in, 97'd0);
        check("arst_busy", 97'(busy), 97'd0);
        check("arst_pending", 97'(pending), 97'd0);
        hps_cd_out = {1'b1, 96'hDEAD};
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("prime_no_rsp", 97'(rsp_data), 97'd0);
        push(Q1);
        tick(1);
        check("post_rst_issue", hps_cd_in, {1'b1, Q1});
        reply(96'h99);
        check("post_rst_valid", 97'(rsp_valid), 97'd1);
        check("post_rst_unsol", 97'(rsp_unsol), 97'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cd_hps_sched.md
# cd_hps_sched

Command scheduler for the HPS CD link: queues 96-bit CD commands from the core-side CD drive logic and issues them to the HPS one at a time. It matches each HPS reply to the outstanding command and enforces a reply timeout. It sits between the CD block and the HPS extension bridge. It drives the bridge's 97-bit CD input word (bit 96 = request toggle) and watches the bridge's 97-bit CD output word (bit 96 = reply toggle).

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- TIMEOUT, 32'd53_000_000, cycles to wait for a reply; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_data  in  96  command word from CD logic
- cmd_valid  in  1  push request
- cmd_ready  out  1  FIFO not full; push accepted when cmd_valid & cmd_ready
- flush  in  1  discard queued commands, abandon the outstanding one
- rsp_data  out  96  reply word, held until the next reply
- rsp_valid  out  1  one-cycle pulse, rsp_data updated
- rsp_unsol  out  1  qualifies rsp_valid: reply arrived with no command outstanding
- rsp_timeout  out  1  one-cycle pulse, outstanding command abandoned
- busy  out  1  command outstanding (state WAIT)
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- hps_cd_in  out  97  to bridge: [95:0] command, [96] request toggle
- hps_cd_out  in  97  from bridge: [95:0] reply, [96] reply toggle

## Operation
- Reset values:
  - hps_cd_in = 0, rsp_data = 0.
  - rsp_valid = rsp_unsol = rsp_timeout = busy = 0.
  - pending = 0, cmd_ready = 1.
  - FSM = PRIME, ack_seen = 0, timeout counter = 0.
- FIFO: circular buffer with DEPTH entries; read and write pointers each one bit wider than the index.
  - Push and pop in the same cycle are allowed. Occupancy is unchanged.
  - A push while full is ignored, because cmd_ready = 0.
- Reply detect: new_ack = (hps_cd_out[96] != ack_seen). On every new_ack, ack_seen <= hps_cd_out[96].
- FSM states:
  - PRIME: the first cycle after reset. Set ack_seen <= hps_cd_out[96] with no report, then go to IDLE.
  - IDLE:
    - new_ack → rsp_data <= hps_cd_out[95:0], rsp_valid = 1, rsp_unsol = 1.
    - Otherwise, if FIFO is non-empty: pop the head, hps_cd_in[95:0] <= head, invert hps_cd_in[96], load counter = TIMEOUT, go to WAIT.
    - A reply takes priority over an issue in the same cycle. The issue happens on the next cycle.
  - WAIT: busy = 1.
    - new_ack → rsp_data <= hps_cd_out[95:0], rsp_valid = 1, rsp_unsol = 0, go to IDLE.
    - Else, if TIMEOUT != 0 and counter == 1 → rsp_timeout = 1, go to IDLE.
    - Else decrement the counter.
    - A reply arriving after a timeout is reported in IDLE as unsolicited.
- flush: highest priority, effective in any state except PRIME.
  - Empties the FIFO, FSM goes to IDLE, no rsp_valid or rsp_timeout pulse that cycle.
  - A coincident new_ack still updates ack_seen, but its reply is dropped.
  - A cmd_valid in the same cycle is dropped.
  - hps_cd_in holds its value, including bit 96. The toggle is never rewound.
- hps_cd_in changes only on issue. Between issues it holds steady for the bridge to read at any time.

## Timing
- Push accepted at edge N into an empty FIFO while IDLE: hps_cd_in and toggle update at edge N+1, busy rises at N+1.
- Reply toggle visible before edge M (in WAIT): rsp_valid high for the cycle after M, FSM in IDLE after M. The next queued command issues at M+1.
- Minimum command-to-command spacing is 2 cycles plus the HPS reply time.
- Timeout: the issue at edge N loads TIMEOUT. rsp_timeout pulses after edge N+TIMEOUT.
- pending and cmd_ready update on the edge following a push or pop. cmd_ready = (pending != DEPTH), registered-equivalent.
- Reset assertion is asynchronous at any time, including mid-WAIT. All outputs return to reset values immediately. Release is synchronous to clk_sys through the design's reset synchronizer.

## Test plan
- Single command: push 96'h0123_4567_89AB_CDEF_0011_2233 → hps_cd_in[95:0] equals it and bit 96 is 1 one cycle later, busy = 1. Toggle hps_cd_out[96] with reply 96'hA5 → rsp_valid pulse, rsp_data = 96'hA5, rsp_unsol = 0, busy = 0.
- Queue fill: push 5 commands back-to-back with DEPTH = 4 and no replies → first issued, pending = 4, cmd_ready = 0 on the last. Each reply issues the next command. Bit 96 alternates 1,0,1,0,1.
- Timeout: TIMEOUT = 100, no reply → rsp_timeout exactly 100 cycles after issue, next command issues one cycle later. A late toggle then gives rsp_valid with rsp_unsol = 1.
- Unsolicited: in IDLE with empty FIFO, toggle hps_cd_out[96] with reply 96'h77 → rsp_valid, rsp_unsol = 1, rsp_data = 96'h77, no issue.
- Flush: 3 queued plus 1 outstanding, assert flush coincident with a reply toggle and a cmd_valid → pending = 0, no pulses, busy = 0, hps_cd_in unchanged. The next push toggles bit 96 relative to its held value.
- Reset mid-WAIT: drop reset_n between edges → hps_cd_in = 0 and busy = 0 immediately. After release, a pre-existing hps_cd_out[96] = 1 produces no reply (PRIME).
